uart_apb_initiator: RTL and testbench

//   APB3 initiator (bus master) driving the UART APB register file: TX data 0x00, RX data 0x04,

---
 rtl/uart_apb_pkg.sv | 6 +
 rtl/uart_apb_wdog.sv | 18 +
 rtl/uart_apb_initiator.sv | 79 +++++++
 tb/tb_uart_apb_initiator.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: FSM states, UART register offsets and STATUS bit indices shared by the APB initiator
package uart_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam logic [4:0] TXDATA = 5'h00, RXDATA = 5'h04, CTRL1 = 5'h08, CTRL2 = 5'h0C, STATUS = 5'h10, CTRL3 = 5'h14;
  localparam int TXRDY = 0, RXRDY = 1, PARITY_ERR = 2, OVERFLOW = 3, FRAMING_ERR = 4;
endpackage

// File: rtl/uart_apb_wdog.sv
// uart_apb_wdog: ACCESS-phase wait counter; expired marks the LIMIT-th ACCESS cycle
module uart_apb_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1) > 8 ? $clog2(LIMIT + 1) : 8;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = en && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/uart_apb_initiator.sv
// uart_apb_initiator: APB3 master running one SETUP+ACCESS transfer per command.
// Define UART_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module uart_apb_initiator
  import uart_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  state_t state, next;
  logic accept, done, abort;
`ifdef UART_APB_TIMEOUT_EN
  uart_apb_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk(pclk), .rst_n(presetn), .load(state == SETUP), .en(state == ACCESS && !pready), .expired(abort)
  );
`else
  // without the watchdog ACCESS never aborts
  assign abort = TIMEOUT_CYCLES < 0;
`endif
  assign accept = cmd_valid && cmd_ready;
  assign done = state == ACCESS && (pready || abort);
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = state == IDLE   ? (accept ? SETUP : IDLE) :
           state == SETUP  ? ACCESS :
           state == ACCESS ? (done ? RESP : ACCESS) :
                             (rsp_ready ? IDLE : RESP);
  end
  // handshake/APB controls are registered from next state so they never glitch
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= next == IDLE;
      psel      <= next == SETUP || next == ACCESS;
      penable   <= next == ACCESS;
      rsp_valid <= next == RESP;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata <= pready && !pwrite ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_apb_initiator.sv
// tb_uart_apb_initiator: directed commands against a transaction-level timing/response model
module tb_uart_apb_initiator;
  localparam int TO = 4;
  logic pclk = 0, presetn = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [4:0] cmd_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [7:0] rsp_rdata;
  logic [4:0] paddr;
  logic psel, penable, pwrite, pready, pslverr;
  logic [7:0] pwdata, prdata;
  int slv_wait = 0, acc_cnt = 0;
  logic [7:0] slv_rdata = 0;
  logic slv_err = 0;
  int vectors = 0, errors = 0;

  uart_apb_initiator #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // slave: inserts slv_wait wait states in every ACCESS phase
  assign prdata = slv_rdata;
  assign pslverr = slv_err;
  assign pready = psel && penable && acc_cnt >= slv_wait;
  always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: k cycles after acceptance, SETUP at k=1, ACCESS at k=2..2+w, response from k=3+w
  logic act = 0, have = 0, boot = 1, m_wr = 0, m_er = 0;
  logic [4:0] m_addr = 0;
  logic [7:0] m_wd = 0, m_rd = 0;
  int since = 0, weff = 0;
  always @(negedge pclk) begin
    if (!presetn) begin
      act = 0;
      have = 0;
      boot = 1;
    end else begin
      if (act) since++;
      chk("psel", psel, act && since >= 1 && since <= 2 + weff);
      chk("penable", penable, act && since >= 2 && since <= 2 + weff);
      chk("rsp_valid", rsp_valid, act && since >= 3 + weff);
      chk("cmd_ready", cmd_ready, !act && !boot);
      chk("apb_cmd", {paddr, pwrite, pwdata}, have ? {m_addr, m_wr, m_wd} : 14'h0);
      boot = 0;
      if (act && since == 2 + weff) begin
        m_rd = pready && !m_wr ? prdata : 8'h00;
        m_er = pready ? pslverr : 1'b1;
      end
      if (act && rsp_valid) begin
        chk("rsp", {rsp_rdata, rsp_err}, {m_rd, m_er});
        if (rsp_ready) act = 0;
      end
      if (cmd_valid && cmd_ready) begin
        act = 1;
        have = 1;
        since = 0;
        m_wr = cmd_write;
        m_addr = cmd_addr;
        m_wd = cmd_wdata;
`ifdef UART_APB_TIMEOUT_EN
        weff = slv_wait < TO - 1 ? slv_wait : TO - 1;
`else
        weff = slv_wait;
`endif
      end
    end
  end

  // hold < 0 raises rsp_ready before the command is issued
  task automatic run(input string name, input logic wr, input logic [4:0] a, input logic [7:0] wd,
                     input int w, input logic [7:0] rd, input logic er, input int hold,
                     input int lat, input logic [7:0] xrd, input logic xer);
    int n = 0;
    slv_wait = w;
    slv_rdata = rd;
    slv_err = er;
    while (!cmd_ready && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk({name, "_ready"}, cmd_ready, 1);
    if (hold < 0) rsp_ready = 1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = wd;
    cmd_valid = 1;
    @(posedge pclk); #1;
    cmd_valid = 0;
    cmd_write = ~wr;
    cmd_addr = ~a;
    cmd_wdata = ~wd;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(posedge pclk); #1;
      n++;
    end
    chk({name, "_lat"}, n + 1, lat);
    chk({name, "_rsp"}, {rsp_rdata, rsp_err}, {xrd, xer});
    if (hold >= 0) begin
      repeat (hold) begin
        @(posedge pclk); #1;
        chk({name, "_hold"}, {cmd_ready, psel, rsp_valid, rsp_rdata, rsp_err}, {3'b001, xrd, xer});
      end
      rsp_ready = 1;
    end
    @(posedge pclk); #1;
    rsp_ready = 0;
    chk({name, "_idle"}, {cmd_ready, rsp_valid, psel}, 3'b100);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_state", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata}, 0);
    presetn = 1;
    run("wr08", 1, 5'h08, 8'h1A, 0, 8'hFF, 0, 0, 3, 8'h00, 0);
    chk("wr08_hold_apb", {paddr, pwrite, pwdata}, {5'h08, 1'b1, 8'h1A});
    run("rd10", 0, 5'h10, 8'h00, 3, 8'h03, 0, 0, 6, 8'h03, 0);
    run("rd04_err", 0, 5'h04, 8'h00, 0, 8'h55, 1, 0, 3, 8'h55, 1);
    run("wr14_early", 1, 5'h14, 8'h7F, 0, 8'h00, 0, -1, 3, 8'h00, 0);
    run("rd0c_late", 0, 5'h0C, 8'h00, 1, 8'hA5, 0, 5, 4, 8'hA5, 0);
    run("wr1c", 1, 5'h1C, 8'h33, 2, 8'h99, 0, 0, 5, 8'h00, 0);
    chk("wr1c_addr", paddr, 5'h1C);
    slv_wait = 5;
    cmd_write = 0;
    cmd_addr = 5'h10;
    cmd_valid = 1;
    @(posedge pclk); #1;
    cmd_valid = 0;
    n = 0;
    while (!penable && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("rst_reach_access", penable, 1);
    @(negedge pclk); #2;
    presetn = 0;
    #1;
    chk("rst_async", {psel, penable, rsp_valid, cmd_ready, paddr}, 9'h0);
    @(negedge pclk);
    @(posedge pclk); #1;
    presetn = 1;
    run("post_rst", 1, 5'h08, 8'h5C, 0, 8'h00, 0, 0, 3, 8'h00, 0);
`ifdef UART_APB_TIMEOUT_EN
    run("timeout", 0, 5'h00, 8'h00, 1000, 8'hC3, 0, 0, TO + 2, 8'h00, 1);
    run("post_to", 0, 5'h10, 8'h00, 0, 8'h11, 0, 0, 3, 8'h11, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
